// File: rtl/tdc_frame_packer.sv
// Packs a CTR_NUMBER x 10-bit snapshot into a byte stream frame:
// header, sequence number, hi/lo byte per channel, then a modulo-256 checksum.
module tdc_frame_packer #(
  parameter int unsigned CTR_NUMBER = 16,
  parameter logic [7:0]  HDR_BYTE   = 8'hA5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [10*CTR_NUMBER-1:0] in_data,
  input  logic                    in_valid,
  output logic [7:0]              out_byte,
  output logic                    out_stb,
  input  logic                    out_rdy,
  output logic                    busy,
  output logic [7:0]              seq_num,
  output logic [7:0]              overrun_cnt
);

  localparam int unsigned ChW = (CTR_NUMBER > 1) ? $clog2(CTR_NUMBER) : 1;
  localparam logic [ChW-1:0] ChLast = ChW'(CTR_NUMBER - 1);

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StSeq,
    StDhi,
    StDlo,
    StCsum
  } state_e;

  state_e                       state_q;
  logic [CTR_NUMBER-1:0][9:0]   snap_q;
  logic [ChW-1:0]               ch_q;
  logic [7:0]                   csum_q;
  logic [7:0]                   seq_q;
  logic [7:0]                   ovr_q;
  logic [7:0]                   byte_q;
  logic                         stb_q;

  logic           accept;
  logic           capture;
  logic [ChW-1:0] ch_nxt;

  assign accept  = stb_q & out_rdy;
  // A new snapshot is taken when idle, or when the checksum byte leaves this cycle.
  assign capture = in_valid & ((state_q == StIdle) | ((state_q == StCsum) & accept));
  assign ch_nxt  = ch_q + ChW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      snap_q  <= '0;
      ch_q    <= '0;
      csum_q  <= '0;
      seq_q   <= '0;
      ovr_q   <= '0;
      byte_q  <= '0;
      stb_q   <= 1'b0;
    end else begin
      if (accept) begin
        csum_q <= csum_q + byte_q;
      end
      if (in_valid && !capture && (ovr_q != 8'hFF)) begin
        ovr_q <= ovr_q + 8'd1;
      end
      if (capture) begin
        snap_q  <= in_data;
        seq_q   <= seq_q + 8'd1;
        csum_q  <= '0;
        ch_q    <= '0;
        state_q <= StHdr;
        byte_q  <= HDR_BYTE;
        stb_q   <= 1'b1;
      end else if (accept) begin
        unique case (state_q)
          StHdr: begin
            state_q <= StSeq;
            byte_q  <= seq_q;
          end
          StSeq: begin
            state_q <= StDhi;
            byte_q  <= {6'b0, snap_q[ch_q][9:8]};
          end
          StDhi: begin
            state_q <= StDlo;
            byte_q  <= snap_q[ch_q][7:0];
          end
          StDlo: begin
            if (ch_q == ChLast) begin
              state_q <= StCsum;
              // Checksum so far plus the low byte being accepted right now.
              byte_q  <= csum_q + byte_q;
            end else begin
              state_q <= StDhi;
              ch_q    <= ch_nxt;
              byte_q  <= {6'b0, snap_q[ch_nxt][9:8]};
            end
          end
          default: begin
            state_q <= StIdle;
            byte_q  <= '0;
            stb_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign out_byte    = byte_q;
  assign out_stb     = stb_q;
  assign busy        = (state_q != StIdle);
  assign seq_num     = seq_q;
  assign overrun_cnt = ovr_q;

endmodule

// File: doc/tdc_frame_packer.md
TDC_FRAME_PACKER -- requirements
Module: tdc_frame_packer

Interface
REQ-001 SHALL have parameter CTR_NUMBER, default 16, giving the number of 10-bit channels per snapshot.
REQ-002 SHALL have parameter HDR_BYTE, default 8'hA5, giving the frame start marker.
REQ-003 SHALL have ports in this order:
- clk  input  1  sole clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  10 x CTR_NUMBER  snapshot from the upstream synchronizer.
- in_valid  input  1  one-cycle strobe; in_data is valid this cycle.
- out_byte  output  8  stream byte.
- out_stb  output  1  out_byte valid.
- out_rdy  input  1  sink accepts out_byte when out_stb && out_rdy.
- busy  output  1  a frame is in progress.
- seq_num  output  8  sequence number of the current or last frame.
- overrun_cnt  output  8  count of dropped snapshots, saturating.
REQ-004 Clocking: one clock; reset is synchronous and active-high (clk, rst).

Function
REQ-005 Frame byte order SHALL be HDR_BYTE, seq_num, then for ch = 0..CTR_NUMBER-1 the pair {6'b0, d[9:8]}, d[7:0], then CSUM.
REQ-006 Frame length SHALL be 2*CTR_NUMBER+3 bytes (35 at default).
REQ-007 CSUM SHALL be the 8-bit modulo-256 sum of all preceding bytes of the frame, header included.
REQ-008 States SHALL be IDLE, HDR, SEQ, DHI, DLO, CSUM.
- IDLE->HDR on capture.
- HDR->SEQ, SEQ->DHI, DHI->DLO on byte accept.
- DLO->DHI on accept when ch < CTR_NUMBER-1, else DLO->CSUM.
- CSUM->IDLE on accept, or CSUM->HDR when a capture occurs in the same cycle.
REQ-009 Capture SHALL occur when in_valid=1 and either state=IDLE, or state=CSUM with out_stb&&out_rdy=1.
- Capture latches all in_data into an internal snapshot register.
- Capture increments seq_num (8-bit wrap, 8'hFF->8'h00).
- Capture clears the running checksum.
REQ-010 The first frame after reset SHALL carry seq_num 8'h01.
REQ-011 in_valid=1 with no capture SHALL leave the snapshot unchanged and increment overrun_cnt, saturating at 8'hFF.
REQ-012 Latency: capture at edge N SHALL present out_stb=1, out_byte=HDR_BYTE after edge N.
REQ-013 Once out_stb=1, out_byte SHALL stay stable until accepted; out_stb SHALL NOT deassert before acceptance.
REQ-014 With out_rdy held 1, one byte SHALL be emitted per cycle with no bubbles, including back-to-back frames.
REQ-015 busy SHALL equal (state != IDLE).
REQ-016 out_stb SHALL be 0 in IDLE.
REQ-017 The channel index SHALL be $clog2(CTR_NUMBER) bits wide and reset to 0 on each capture.
REQ-018 The checksum accumulator SHALL be 8 bits and add each byte as it is accepted; CSUM presents the accumulated value.
REQ-019 in_data SHALL be ignored outside a capture cycle; later in_data changes SHALL NOT alter a frame in progress.

Reset
REQ-020 rst=1 at an edge SHALL force, at any state including mid-frame:
- state=IDLE, out_stb=0, out_byte=0, busy=0.
- seq_num=0, overrun_cnt=0, checksum=0, ch=0.
REQ-021 A partially sent frame SHALL be abandoned by reset, with no CSUM emitted.
REQ-022 in_valid during a reset cycle SHALL be ignored.

Verification
REQ-023 The bench SHALL cover:
- All-zero snapshot, out_rdy=1 -> 35 consecutive bytes A5,01,00...00,A6; busy high for 35 cycles.
- All channels 10'h3FF, seq 1 -> pairs 03,FF; CSUM = (A5+01+16*0x102) mod 256 = 8'hC6.
- out_rdy toggled randomly -> out_byte stable while stalled; byte sequence identical to the out_rdy=1 case.
- in_valid pulsed mid-frame twice -> overrun_cnt=2; frame content unchanged.
- in_valid coincident with CSUM accept -> next cycle out_byte=A5, seq increments; 300 back-to-back captures -> seq wraps FF->00, overrun_cnt stays 0.
- rst asserted at byte 10 -> next cycle out_stb=0, seq_num=0; next capture emits seq 01.
